// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: signal bundle between the pipeline, the load/store controller
// and the data bus.
//   pipeline request : req_valid/req_ready, req_write, req_size, req_unsigned,
//                      req_addr, req_wdata, req_page_fault, flush
//   bus request      : dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
//   bus response     : dresp_addr_ok, dresp_data_ok, dresp_data
//   pipeline response: resp_valid/resp_ready, resp_data, resp_exc, resp_cause,
//                      resp_tval
// modport master: the controller. modport slave: pipeline plus bus environment.
interface lsu_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  req_page_fault;
  logic                  flush;

  logic                  dreq_valid;
  logic [ADDR_W-1:0]     dreq_addr;
  logic [1:0]            dreq_size;
  logic [DATA_W/8-1:0]   dreq_strobe;
  logic [DATA_W-1:0]     dreq_data;
  logic                  dresp_addr_ok;
  logic                  dresp_data_ok;
  logic [DATA_W-1:0]     dresp_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_exc;
  logic [3:0]            resp_cause;
  logic [ADDR_W-1:0]     resp_tval;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
           req_page_fault, flush, dresp_addr_ok, dresp_data_ok, dresp_data,
           resp_ready,
    output req_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           resp_valid, resp_data, resp_exc, resp_cause, resp_tval
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
           req_page_fault, flush, dresp_addr_ok, dresp_data_ok, dresp_data,
           resp_ready,
    input  req_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           resp_valid, resp_data, resp_exc, resp_cause, resp_tval
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: registered, handshaked load/store controller for the memory stage.
// Accepts one access from the pipeline, holds the bus request until the
// address is accepted, waits for data, then returns a formatted load result
// (lane select plus sign/zero extension) or a misalign/page-fault exception.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   io    - lsu_ctrl_if.master (pipeline request/response and data bus)
// Parameters: DATA_W (32 or 64), ADDR_W.
// Build option: define LSU_MISALIGN_CHECK_EN to raise misalign exceptions
// (cause 4 load, 6 store); when undefined, accesses are forced aligned by
// clearing the address bits below the size, and 8-byte accesses on a 32-bit
// bus are narrowed to 4 bytes.
module lsu_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.master io
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state;
  logic              killed;
  logic              op_write;
  logic              op_unsigned;
  logic [1:0]        op_size;
  logic [OFF_W-1:0]  op_off;

  // Request decode (valid while sitting in IDLE).
  logic              accept;
  logic              misalign;
  logic [1:0]        eff_size;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] eff_addr;
  logic [OFF_W-1:0]  req_off;
  logic [STRB_W-1:0] strobe_base;
  logic [STRB_W-1:0] st_strobe;
  logic [DATA_W-1:0] st_data;

  // Load formatting (uses the attributes latched at accept).
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_mask;
  logic [DATA_W-1:0] ld_msb;
  logic              ld_neg;
  logic [DATA_W-1:0] ld_data;

  // A flush in the same cycle as a request blocks the accept, so the
  // pipeline never has a just-killed access slip into the bus.
  assign io.req_ready = (state == IDLE) && !reset && !io.flush;
  assign accept       = io.req_ready && io.req_valid;

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    eff_size  = io.req_size;
    misalign  = 1'b0;
`ifndef LSU_MISALIGN_CHECK_EN
    if ((DATA_W == 32) && (io.req_size == 2'd3)) eff_size = 2'd2;
`endif
    size_mask = '0;
    case (eff_size)
      2'd1:    size_mask[0]   = 1'b1;
      2'd2:    size_mask[1:0] = 2'b11;
      2'd3:    size_mask[2:0] = 3'b111;
      default: size_mask      = '0;
    endcase
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (|(io.req_addr & size_mask)) ||
               ((DATA_W == 32) && (io.req_size == 2'd3));
    eff_addr = io.req_addr;
`else
    eff_addr = io.req_addr & ~size_mask;
`endif
    req_off = eff_addr[OFF_W-1:0];

    case (eff_size)
      2'd0:    strobe_base = STRB_W'(8'h01);
      2'd1:    strobe_base = STRB_W'(8'h03);
      2'd2:    strobe_base = STRB_W'(8'h0F);
      default: strobe_base = '1;
    endcase
    st_strobe = strobe_base << req_off;
    st_data   = io.req_wdata << {req_off, 3'b000};
  end

  // Sign bit located via the top bit of the field mask, which keeps the
  // extension logic width-agnostic for both bus widths.
  always_comb begin
    ld_shift = io.dresp_data >> {op_off, 3'b000};
    case (op_size)
      2'd0:    ld_mask = DATA_W'(8'hFF);
      2'd1:    ld_mask = DATA_W'(16'hFFFF);
      2'd2:    ld_mask = DATA_W'(32'hFFFF_FFFF);
      default: ld_mask = '1;
    endcase
    ld_msb  = ld_mask ^ (ld_mask >> 1);
    ld_neg  = !op_unsigned && (|(ld_shift & ld_msb));
    ld_data = (ld_shift & ld_mask) | (ld_neg ? ~ld_mask : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      killed         <= 1'b0;
      op_write       <= 1'b0;
      op_unsigned    <= 1'b0;
      op_size        <= 2'd0;
      op_off         <= '0;
      io.dreq_valid  <= 1'b0;
      io.dreq_addr   <= '0;
      io.dreq_size   <= 2'd0;
      io.dreq_strobe <= '0;
      io.dreq_data   <= '0;
      io.resp_valid  <= 1'b0;
      io.resp_data   <= '0;
      io.resp_exc    <= 1'b0;
      io.resp_cause  <= 4'd0;
      io.resp_tval   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_write    <= io.req_write;
            op_unsigned <= io.req_unsigned;
            op_size     <= eff_size;
            op_off      <= req_off;
            killed      <= 1'b0;
            if (misalign || io.req_page_fault) begin
              // Exceptions skip the bus entirely; misalign outranks page fault.
              state         <= RESP;
              io.resp_valid <= 1'b1;
              io.resp_exc   <= 1'b1;
              io.resp_data  <= '0;
              io.resp_tval  <= io.req_addr;
              if (misalign) io.resp_cause <= io.req_write ? 4'd6 : 4'd4;
              else          io.resp_cause <= io.req_write ? 4'd15 : 4'd13;
            end else begin
              state          <= REQ;
              io.dreq_valid  <= 1'b1;
              io.dreq_addr   <= eff_addr;
              io.dreq_size   <= eff_size;
              io.dreq_strobe <= io.req_write ? st_strobe : '0;
              io.dreq_data   <= io.req_write ? st_data : '0;
            end
          end
        end

        REQ: begin
          // A flush cannot retract the request; it only marks the result dead.
          if (io.flush) killed <= 1'b1;
          if (io.dresp_addr_ok) begin
            io.dreq_valid <= 1'b0;
            if (io.dresp_data_ok) begin
              if (killed || io.flush) begin
                state <= IDLE;
              end else begin
                state         <= RESP;
                io.resp_valid <= 1'b1;
                io.resp_exc   <= 1'b0;
                io.resp_cause <= 4'd0;
                io.resp_tval  <= '0;
                io.resp_data  <= op_write ? '0 : ld_data;
              end
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (io.flush) killed <= 1'b1;
          if (io.dresp_data_ok) begin
            if (killed || io.flush) begin
              state <= IDLE;
            end else begin
              state         <= RESP;
              io.resp_valid <= 1'b1;
              io.resp_exc   <= 1'b0;
              io.resp_cause <= 4'd0;
              io.resp_tval  <= '0;
              io.resp_data  <= op_write ? '0 : ld_data;
            end
          end
        end

        RESP: begin
          if (io.resp_ready || io.flush) begin
            state         <= IDLE;
            io.resp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed-vector bench for lsu_ctrl (DATA_W = ADDR_W = 64).
// Expected values are hand-computed; the misalign cases select their
// expectation according to LSU_MISALIGN_CHECK_EN.
module tb_lsu_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  lsu_ctrl_if #(.DATA_W(64), .ADDR_W(64)) io ();

  lsu_ctrl #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in a cycle where req_ready is high; returns in the
  // cycle after the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd, input logic pf);
    int n;
    n = 0;
    while (!io.req_ready && n < 20) begin
      tick();
      n++;
    end
    check("issue_ready", 64'(io.req_ready), 64'd1);
    io.req_valid      = 1'b1;
    io.req_write      = w;
    io.req_size       = sz;
    io.req_unsigned   = uns;
    io.req_addr       = a;
    io.req_wdata      = wd;
    io.req_page_fault = pf;
    tick();
    io.req_valid      = 1'b0;
    io.req_page_fault = 1'b0;
  endtask

  task automatic bus_done(input logic [63:0] d);
    io.dresp_addr_ok = 1'b1;
    io.dresp_data_ok = 1'b1;
    io.dresp_data    = d;
    tick();
    io.dresp_addr_ok = 1'b0;
    io.dresp_data_ok = 1'b0;
  endtask

  task automatic consume();
    io.resp_ready = 1'b1;
    tick();
    io.resp_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    io.req_valid = 1'b0; io.req_write = 1'b0; io.req_size = 2'd0;
    io.req_unsigned = 1'b0; io.req_addr = '0; io.req_wdata = '0;
    io.req_page_fault = 1'b0; io.flush = 1'b0;
    io.dresp_addr_ok = 1'b0; io.dresp_data_ok = 1'b0; io.dresp_data = '0;
    io.resp_ready = 1'b0;

    // Reset state.
    tick(); tick();
    check("rst_req_ready",  64'(io.req_ready),  64'd0);
    check("rst_dreq_valid", 64'(io.dreq_valid), 64'd0);
    check("rst_resp_valid", 64'(io.resp_valid), 64'd0);
    check("rst_resp_exc",   64'(io.resp_exc),   64'd0);
    check("rst_dreq_addr",  io.dreq_addr,       64'd0);
    check("rst_resp_cause", 64'(io.resp_cause), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(io.req_ready), 64'd1);
    tick();

    // Byte store into lane 3.
    issue(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hAB, 1'b0);
    check("sb_dreq_valid",  64'(io.dreq_valid),  64'd1);
    check("sb_strobe",      64'(io.dreq_strobe), 64'h08);
    check("sb_data",        io.dreq_data,        64'h0000_0000_AB00_0000);
    check("sb_addr",        io.dreq_addr,        64'h8000_0003);
    check("sb_busy_ready",  64'(io.req_ready),   64'd0);
    bus_done(64'hFFFF_FFFF_FFFF_FFFF);
    check("sb_resp_valid",  64'(io.resp_valid),  64'd1);
    check("sb_resp_data",   io.resp_data,        64'd0);
    check("sb_resp_exc",    64'(io.resp_exc),    64'd0);
    check("sb_dreq_drop",   64'(io.dreq_valid),  64'd0);
    consume();
    check("sb_resp_clear",  64'(io.resp_valid),  64'd0);
    check("sb_b2b_ready",   64'(io.req_ready),   64'd1);

    // Halfword loads from lane 6, signed then unsigned.
    issue(1'b0, 2'd1, 1'b0, 64'h1006, 64'd0, 1'b0);
    check("lh_strobe",      64'(io.dreq_strobe), 64'd0);
    check("lh_size",        64'(io.dreq_size),   64'd1);
    bus_done(64'h8001_0000_0000_0000);
    check("lh_data",        io.resp_data,        64'hFFFF_FFFF_FFFF_8001);
    consume();
    issue(1'b0, 2'd1, 1'b1, 64'h1006, 64'd0, 1'b0);
    bus_done(64'h8001_0000_0000_0000);
    check("lhu_data",       io.resp_data,        64'h0000_0000_0000_8001);
    consume();

    // Misaligned word load at 0x1002.
    issue(1'b0, 2'd2, 1'b0, 64'h1002, 64'd0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lwmis_valid",    64'(io.resp_valid),  64'd1);
    check("lwmis_exc",      64'(io.resp_exc),    64'd1);
    check("lwmis_cause",    64'(io.resp_cause),  64'd4);
    check("lwmis_tval",     io.resp_tval,        64'h1002);
    check("lwmis_no_bus",   64'(io.dreq_valid),  64'd0);
`else
    check("lwal_valid",     64'(io.dreq_valid),  64'd1);
    check("lwal_addr",      io.dreq_addr,        64'h1000);
    bus_done(64'h1234_5678_9ABC_DEF0);
    check("lwal_data",      io.resp_data,        64'hFFFF_FFFF_9ABC_DEF0);
`endif
    consume();

    // Misaligned doubleword store at 0x1004.
    issue(1'b1, 2'd3, 1'b0, 64'h1004, 64'h0102_0304_0506_0708, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("sdmis_cause",    64'(io.resp_cause),  64'd6);
    check("sdmis_no_bus",   64'(io.dreq_valid),  64'd0);
`else
    check("sdal_addr",      io.dreq_addr,        64'h1000);
    check("sdal_strobe",    64'(io.dreq_strobe), 64'hFF);
    bus_done(64'd0);
`endif
    consume();

    // Address accept delayed three cycles, data two cycles later.
    issue(1'b0, 2'd3, 1'b0, 64'h2000, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("dly_valid_hold", 64'(io.dreq_valid), 64'd1);
      check("dly_addr_hold",  io.dreq_addr,       64'h2000);
      tick();
    end
    check("dly_valid_c4",   64'(io.dreq_valid),  64'd1);
    io.dresp_addr_ok = 1'b1;
    tick();
    io.dresp_addr_ok = 1'b0;
    check("dly_wait_drop",  64'(io.dreq_valid),  64'd0);
    check("dly_no_resp",    64'(io.resp_valid),  64'd0);
    tick();
    io.dresp_data_ok = 1'b1;
    io.dresp_data    = 64'h1122_3344_5566_7788;
    tick();
    io.dresp_data_ok = 1'b0;
    check("dly_resp_valid", 64'(io.resp_valid),  64'd1);
    check("dly_resp_data",  io.resp_data,        64'h1122_3344_5566_7788);
    io.dresp_data = '0;
    tick();
    check("dly_resp_stable", io.resp_data,       64'h1122_3344_5566_7788);
    check("dly_valid_stable", 64'(io.resp_valid), 64'd1);
    consume();

    // Flush while the request is on the bus.
    issue(1'b1, 2'd2, 1'b0, 64'h3004, 64'hDEAD_BEEF, 1'b0);
    check("fl_strobe",      64'(io.dreq_strobe), 64'hF0);
    check("fl_data",        io.dreq_data,        64'hDEAD_BEEF_0000_0000);
    io.flush = 1'b1;
    #1;
    check("fl_ready_low",   64'(io.req_ready),   64'd0);
    tick();
    io.flush = 1'b0;
    check("fl_no_retract",  64'(io.dreq_valid),  64'd1);
    io.dresp_addr_ok = 1'b1;
    tick();
    io.dresp_addr_ok = 1'b0;
    check("fl_wait_ready",  64'(io.req_ready),   64'd0);
    io.dresp_data_ok = 1'b1;
    tick();
    io.dresp_data_ok = 1'b0;
    check("fl_no_resp",     64'(io.resp_valid),  64'd0);
    check("fl_ready_back",  64'(io.req_ready),   64'd1);

    // Flush while a response is pending drops it.
    issue(1'b0, 2'd0, 1'b1, 64'h3001, 64'd0, 1'b0);
    bus_done(64'h0000_0000_0000_C300);
    check("lbu_data",       io.resp_data,        64'hC3);
    io.flush = 1'b1;
    tick();
    io.flush = 1'b0;
    check("flresp_drop",    64'(io.resp_valid),  64'd0);

    // Flush together with req_valid: request is not taken.
    io.flush = 1'b1;
    io.req_valid = 1'b1;
    io.req_addr = 64'h5000;
    tick();
    io.flush = 1'b0;
    io.req_valid = 1'b0;
    check("flreq_no_bus",   64'(io.dreq_valid),  64'd0);
    check("flreq_no_resp",  64'(io.resp_valid),  64'd0);

    // Page faults: store fault, then misalign-vs-fault priority on a load.
    issue(1'b1, 2'd3, 1'b0, 64'h4000, 64'd0, 1'b1);
    check("spf_valid",      64'(io.resp_valid),  64'd1);
    check("spf_cause",      64'(io.resp_cause),  64'd15);
    check("spf_tval",       io.resp_tval,        64'h4000);
    check("spf_no_bus",     64'(io.dreq_valid),  64'd0);
    consume();
    issue(1'b0, 2'd1, 1'b0, 64'h4001, 64'd0, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
    check("prio_cause",     64'(io.resp_cause),  64'd4);
`else
    check("prio_cause",     64'(io.resp_cause),  64'd13);
`endif
    check("prio_tval",      io.resp_tval,        64'h4001);
    consume();

    // Reset asserted while waiting for data.
    issue(1'b1, 2'd3, 1'b0, 64'h6008, 64'h55, 1'b0);
    io.dresp_addr_ok = 1'b1;
    tick();
    io.dresp_addr_ok = 1'b0;
    check("rw_in_wait",     64'(io.dreq_valid),  64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rw_ready",       64'(io.req_ready),   64'd0);
    check("rw_dreq_addr",   io.dreq_addr,        64'd0);
    check("rw_dreq_strobe", 64'(io.dreq_strobe), 64'd0);
    check("rw_dreq_data",   io.dreq_data,        64'd0);
    check("rw_dreq_size",   64'(io.dreq_size),   64'd0);
    tick();
    reset = 1'b0;
    io.dresp_data_ok = 1'b1;
    #1;
    check("rw_ready_back",  64'(io.req_ready),   64'd1);
    tick();
    io.dresp_data_ok = 1'b0;
    check("rw_no_resp",     64'(io.resp_valid),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
